// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the common-data-bus arbiter slice.
package cdb_arbiter_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TAG_W   = 4;
    localparam int DEF_RSNUM_W = 3;
    localparam int DEF_DEPTH   = 4;

    // ROB tag value meaning "no destination"; such results are never broadcast.
    localparam int TAG_FREE = 0;

    localparam logic VALID   = 1'b1;
    localparam logic INVALID = 1'b0;

    // Which producer FIFO won the bus most recently under contention.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSB = 1'b1
    } grant_e;

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO with a combinational head; one per CDB producer.
module cdb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses the push even if it pops in the same cycle.
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    assign empty = (count == '0);
    assign full  = (count == (AW + 1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write.
    // NOTE: the array has no reset; stale slots are unreachable once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: buffers ALU and load/store results, broadcasts one per cycle
// round-robin, and tells the ALU reservation station which entry to free.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int RSNUM_W = DEF_RSNUM_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alu_valid,
    input  logic [RSNUM_W-1:0] alu_rsnum,
    input  logic [TAG_W-1:0]   alu_tag,
    input  logic [DATA_W-1:0]  alu_data,
    output logic               alu_full,
    input  logic               lsb_valid,
    input  logic [TAG_W-1:0]   lsb_tag,
    input  logic [DATA_W-1:0]  lsb_data,
    output logic               lsb_full,
    output logic               cdb_valid,
    output logic [TAG_W-1:0]   cdb_tag,
    output logic [DATA_W-1:0]  cdb_data,
    output logic               alu_finish,
    output logic [RSNUM_W-1:0] alu_fin_rsnum,
    output logic               overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [RSNUM_W-1:0] rsnum;
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
    } alu_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } lsb_entry_t;

    alu_entry_t    alu_head;
    lsb_entry_t    lsb_head;
    logic          alu_req, lsb_req;
    logic          alu_push, lsb_push;
    logic          alu_empty, lsb_empty;
    logic [CW-1:0] alu_count, lsb_count;
    logic          grant_alu, grant_lsb;
    grant_e        last_grant;

    // Results headed for the free tag are dropped silently; flush discards pushes.
    assign alu_req  = alu_valid && (alu_tag != TAG_W'(TAG_FREE));
    assign lsb_req  = lsb_valid && (lsb_tag != TAG_W'(TAG_FREE));
    assign alu_push = alu_req && !flush;
    assign lsb_push = lsb_req && !flush;

    cdb_fifo #(.W($bits(alu_entry_t)), .DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (alu_push),
        .din   ({alu_rsnum, alu_tag, alu_data}),
        .pop   (grant_alu),
        .dout  (alu_head),
        .empty (alu_empty),
        .full  (alu_full),
        .count (alu_count)
    );

    cdb_fifo #(.W($bits(lsb_entry_t)), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (lsb_push),
        .din   ({lsb_tag, lsb_data}),
        .pop   (grant_lsb),
        .dout  (lsb_head),
        .empty (lsb_empty),
        .full  (lsb_full),
        .count (lsb_count)
    );

    // Occupancy can never exceed the FIFO depth.
    assert property (@(posedge clk) disable iff (rst) (alu_count <= CW'(DEPTH)) && (lsb_count <= CW'(DEPTH)));

    // Round-robin grant from registered FIFO state; no grant during flush.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsb = 1'b0;
        if (!flush) begin
            if (!alu_empty && !lsb_empty) begin
                if (last_grant == GRANT_LSB) grant_alu = 1'b1;
                else                         grant_lsb = 1'b1;
            end else if (!alu_empty) begin
                grant_alu = 1'b1;
            end else if (!lsb_empty) begin
                grant_lsb = 1'b1;
            end
        end
    end

    // Remember the winner of each contention so the other side wins next time.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            last_grant <= GRANT_LSB;
        end else if (!alu_empty && !lsb_empty) begin
            last_grant <= grant_alu ? GRANT_ALU : GRANT_LSB;
        end
    end

    // Broadcast register: loads the granted head on the edge that pops it.
    always_ff @(posedge clk) begin
        if (rst || flush || !(grant_alu || grant_lsb)) begin
            cdb_valid     <= INVALID;
            cdb_tag       <= TAG_W'(TAG_FREE);
            cdb_data      <= '0;
            alu_finish    <= 1'b0;
            alu_fin_rsnum <= '0;
        end else if (grant_alu) begin
            cdb_valid     <= VALID;
            cdb_tag       <= alu_head.tag;
            cdb_data      <= alu_head.data;
            alu_finish    <= 1'b1;
            alu_fin_rsnum <= alu_head.rsnum;
        end else begin
            cdb_valid     <= VALID;
            cdb_tag       <= lsb_head.tag;
            cdb_data      <= lsb_head.data;
            alu_finish    <= 1'b0;
            alu_fin_rsnum <= '0;
        end
    end

    // Sticky drop indicator; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (!flush && ((alu_req && alu_full) || (lsb_req && lsb_full))) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        alu_valid, lsb_valid;
    logic [2:0]  alu_rsnum;
    logic [3:0]  alu_tag, lsb_tag;
    logic [31:0] alu_data, lsb_data;
    logic        alu_full, lsb_full;
    logic        cdb_valid, alu_finish, overflow;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  alu_fin_rsnum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [2:0]  rsnum;
    } ent_t;

    ent_t qa[$];
    ent_t ql[$];

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alu_valid     (alu_valid),
        .alu_rsnum     (alu_rsnum),
        .alu_tag       (alu_tag),
        .alu_data      (alu_data),
        .alu_full      (alu_full),
        .lsb_valid     (lsb_valid),
        .lsb_tag       (lsb_tag),
        .lsb_data      (lsb_data),
        .lsb_full      (lsb_full),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .alu_finish    (alu_finish),
        .alu_fin_rsnum (alu_fin_rsnum),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
        alu_rsnum = '0;
        alu_tag   = '0;
        alu_data  = '0;
        lsb_tag   = '0;
        lsb_data  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Compare the current broadcast with the head of the matching model queue.
    task automatic observe();
        ent_t e;
        if (cdb_valid) begin
            if (alu_finish) begin
                if (qa.size() == 0) begin
                    check("t4_alu_unexpected", 64'(cdb_tag), 64'hff);
                end else begin
                    e = qa.pop_front();
                    check("t4_alu_tag", 64'(cdb_tag), 64'(e.tag));
                    check("t4_alu_data", 64'(cdb_data), 64'(e.data));
                    check("t4_alu_rsnum", 64'(alu_fin_rsnum), 64'(e.rsnum));
                end
            end else begin
                if (ql.size() == 0) begin
                    check("t4_lsb_unexpected", 64'(cdb_tag), 64'hff);
                end else begin
                    e = ql.pop_front();
                    check("t4_lsb_tag", 64'(cdb_tag), 64'(e.tag));
                    check("t4_lsb_data", 64'(cdb_data), 64'(e.data));
                    check("t4_lsb_rsnum", 64'(alu_fin_rsnum), 64'h0);
                end
            end
        end
    endtask

    logic [3:0] exp_tag [4];
    logic       exp_fin [4];
    logic       saw_full;
    int         seen;
    int         budget;

    initial begin
        exp_tag = '{4'd1, 4'd9, 4'd2, 4'd10};
        exp_fin = '{1'b1, 1'b0, 1'b1, 1'b0};

        // 1. Reset state.
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_valid", 64'(cdb_valid), 64'h0);
        check("rst_tag", 64'(cdb_tag), 64'h0);
        check("rst_data", 64'(cdb_data), 64'h0);
        check("rst_finish", 64'(alu_finish), 64'h0);
        check("rst_rsnum", 64'(alu_fin_rsnum), 64'h0);
        check("rst_full", 64'({alu_full, lsb_full}), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        rst = 1'b0;

        // 2. Single ALU result, minimum latency.
        alu_valid = 1'b1;
        alu_rsnum = 3'd2;
        alu_tag   = 4'd3;
        alu_data  = 32'h1234_5678;
        cycle();
        idle();
        check("t2_not_yet", 64'(cdb_valid), 64'h0);
        cycle();
        check("t2_valid", 64'(cdb_valid), 64'h1);
        check("t2_tag", 64'(cdb_tag), 64'h3);
        check("t2_data", 64'(cdb_data), 64'h1234_5678);
        check("t2_finish", 64'(alu_finish), 64'h1);
        check("t2_rsnum", 64'(alu_fin_rsnum), 64'h2);
        cycle();
        check("t2_after", 64'({cdb_valid, cdb_tag, cdb_data, alu_finish, alu_fin_rsnum}), 64'h0);

        // 3. Contention alternates, ALU first.
        do_reset();
        alu_valid = 1'b1; alu_tag = 4'd1; alu_rsnum = 3'd5; alu_data = 32'hA1;
        lsb_valid = 1'b1; lsb_tag = 4'd9; lsb_data = 32'hB9;
        cycle();
        alu_tag = 4'd2; alu_rsnum = 3'd6; alu_data = 32'hA2;
        lsb_tag = 4'd10; lsb_data = 32'hBA;
        cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            check("t3_valid", 64'(cdb_valid), 64'h1);
            check("t3_tag", 64'(cdb_tag), 64'(exp_tag[i]));
            check("t3_finish", 64'(alu_finish), 64'(exp_fin[i]));
            cycle();
        end
        check("t3_done", 64'(cdb_valid), 64'h0);

        // 4. Both producers saturate, obeying the full flags.
        do_reset();
        saw_full = 1'b0;
        for (int c = 0; c < 12; c++) begin
            observe();
            if (alu_full || lsb_full) saw_full = 1'b1;
            alu_valid = !alu_full;
            alu_tag   = 4'(1 + c % 7);
            alu_rsnum = 3'(c % 8);
            alu_data  = 32'hA000_0000 + 32'(c);
            if (alu_valid) qa.push_back('{alu_tag, alu_data, alu_rsnum});
            lsb_valid = !lsb_full;
            lsb_tag   = 4'(8 + c % 8);
            lsb_data  = 32'hB000_0000 + 32'(c);
            if (lsb_valid) ql.push_back('{lsb_tag, lsb_data, 3'd0});
            cycle();
        end
        idle();
        budget = 0;
        while ((qa.size() != 0 || ql.size() != 0) && budget < 30) begin
            observe();
            if (qa.size() != 0 || ql.size() != 0) cycle();
            budget++;
        end
        check("t4_drained", 64'(qa.size() + ql.size()), 64'h0);
        check("t4_saw_full", 64'(saw_full), 64'h1);
        check("t4_overflow", 64'(overflow), 64'h0);
        cycle();
        check("t4_idle", 64'(cdb_valid), 64'h0);

        // 5. Flush discards pending entries and a same-cycle push.
        do_reset();
        alu_valid = 1'b1; alu_tag = 4'd4; alu_data = 32'h44;
        lsb_valid = 1'b1; lsb_tag = 4'd11; lsb_data = 32'hBB;
        cycle();
        alu_tag = 4'd5; alu_data = 32'h55;
        lsb_tag = 4'd12; lsb_data = 32'hCC;
        cycle();
        check("t5_pre_tag", 64'(cdb_tag), 64'h4);
        idle();
        flush = 1'b1;
        alu_valid = 1'b1; alu_tag = 4'd7; alu_data = 32'h77;
        cycle();
        idle();
        check("t5_flush_valid", 64'(cdb_valid), 64'h0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (cdb_valid) seen++;
        end
        check("t5_no_broadcast", 64'(seen), 64'h0);

        // 6. Overflow is sticky and the dropped tag never appears.
        budget = 0;
        while (!alu_full && budget < 30) begin
            alu_valid = 1'b1; alu_tag = 4'd1; alu_data = 32'h1;
            lsb_valid = !lsb_full; lsb_tag = 4'd9; lsb_data = 32'h9;
            cycle();
            budget++;
        end
        check("t6_alu_full", 64'(alu_full), 64'h1);
        check("t6_pre_overflow", 64'(overflow), 64'h0);
        idle();
        alu_valid = 1'b1; alu_tag = 4'd5; alu_data = 32'h5;
        cycle();
        idle();
        check("t6_overflow", 64'(overflow), 64'h1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (cdb_valid && cdb_tag == 4'd5) seen++;
            cycle();
        end
        check("t6_tag5_absent", 64'(seen), 64'h0);
        check("t6_sticky", 64'(overflow), 64'h1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t6_flush_keeps", 64'(overflow), 64'h1);
        do_reset();
        check("t6_rst_clears", 64'(overflow), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
